// File: rtl/muldiv_ctrl_if.sv
// Execute-stage handshake between the pipeline and the iterative mul/div sequencer.
interface muldiv_ctrl_if #(
  parameter int XLEN = 64
);
  logic            start;
  logic [2:0]      op;
  logic            word;
  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;
  logic            flush;
  logic            busy;
  logic            ex_stall;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, op, word, op1, op2, flush,
    input  busy, ex_stall, done, result
  );

  modport slave (
    input  start, op, word, op1, op2, flush,
    output busy, ex_stall, done, result
  );
endinterface

// File: rtl/muldiv_ctrl.sv
// RV64M sequencer: radix-2 shift-add multiply / restoring divide on magnitudes,
// sign and field selection applied in a single fixup cycle.
module muldiv_ctrl #(
  parameter int XLEN = 64
) (
  input logic          clk,
  input logic          rst,
  muldiv_ctrl_if.slave bus
);
  localparam int HW = XLEN / 2;
  localparam int CW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;
  state_t state, state_nx;

  logic [2:0]      op_q;
  logic            word_q, s1_q, s2_q;
  logic [XLEN-1:0] hi, lo, opnd, res_q;
  logic [CW-1:0]   cnt;
  logic            busy_q, done_q;

  function automatic logic [XLEN-1:0] sext_w(input logic [XLEN-1:0] x);
    return {{HW{x[HW-1]}}, x[HW-1:0]};
  endfunction

  logic            is_div, eff_word, sg1, sg2, s1, s2, div0, ovf, accept;
  logic [XLEN-1:0] ext1, ext2, mag1, mag2, spec_res;

  always_comb begin
    is_div   = bus.op[2];
    eff_word = bus.word & ((bus.op == 3'd0) | is_div);
    sg1      = bus.op inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd6};
    sg2      = bus.op inside {3'd0, 3'd1, 3'd4, 3'd6};
    ext1     = bus.op1;
    ext2     = bus.op2;
    if (eff_word) begin
      ext1 = sg1 ? sext_w(bus.op1) : {{HW{1'b0}}, bus.op1[HW-1:0]};
      ext2 = sg2 ? sext_w(bus.op2) : {{HW{1'b0}}, bus.op2[HW-1:0]};
    end
    s1   = sg1 & ext1[XLEN-1];
    s2   = sg2 & ext2[XLEN-1];
    mag1 = s1 ? -ext1 : ext1;
    mag2 = s2 ? -ext2 : ext2;
    div0 = is_div & (ext2 == '0);
    ovf  = is_div & ~bus.op[0] &
           (eff_word ? ((bus.op1[HW-1:0] == {1'b1, {(HW-1){1'b0}}}) & (bus.op2[HW-1:0] == {HW{1'b1}}))
                     : ((bus.op1 == {1'b1, {(XLEN-1){1'b0}}}) & (bus.op2 == {XLEN{1'b1}})));
    // op[1] distinguishes REM* from DIV*; ext1 already holds the most-negative value on overflow
    if (div0) spec_res = bus.op[1] ? ext1 : {XLEN{1'b1}};
    else      spec_res = bus.op[1] ? '0 : ext1;
    if (eff_word) spec_res = sext_w(spec_res);
    accept = (state == IDLE) & bus.start & ~bus.flush;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = (div0 | ovf) ? DONE : CALC;
      CALC:    if (cnt == CW'(1)) state_nx = FIXUP;
      FIXUP:   state_nx = DONE;
      default: state_nx = IDLE;
    endcase
    if (bus.flush) state_nx = IDLE;
  end

  logic [XLEN:0] sum, shf, diff;
  always_comb begin
    sum  = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
    shf  = {hi, lo[XLEN-1]};
    diff = shf - {1'b0, opnd};
  end

  logic [2*XLEN-1:0] mprod, sprod;
  logic [XLEN-1:0]   quo, rmd, raw, fix_res;
  always_comb begin
    // a word multiply runs only HW steps, so its product sits HW bits higher
    mprod = word_q ? {{HW{1'b0}}, hi, lo[XLEN-1:HW]} : {hi, lo};
    sprod = (s1_q ^ s2_q) ? -mprod : mprod;
    quo   = (s1_q ^ s2_q) ? -lo : lo;
    rmd   = s1_q ? -hi : hi;
    case (op_q)
      3'd0:       raw = sprod[XLEN-1:0];
      3'd1, 3'd2,
      3'd3:       raw = sprod[2*XLEN-1:XLEN];
      3'd4, 3'd5: raw = quo;
      default:    raw = rmd;
    endcase
    fix_res = word_q ? sext_w(raw) : raw;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q   <= '0;
      word_q <= 1'b0;
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      opnd   <= '0;
      cnt    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      res_q  <= '0;
    end else begin
      busy_q <= (state_nx == CALC) | (state_nx == FIXUP);
      done_q <= (state_nx == DONE);
      if (state_nx == DONE) res_q <= (state == IDLE) ? spec_res : fix_res;
      if (accept) begin
        op_q   <= bus.op;
        word_q <= eff_word;
        s1_q   <= s1;
        s2_q   <= s2;
        cnt    <= eff_word ? CW'(HW) : CW'(XLEN);
        hi     <= '0;
        // divide: dividend walks out of lo's MSB, so a word dividend starts in the top half
        lo     <= is_div ? (eff_word ? (mag1 << HW) : mag1) : mag2;
        opnd   <= is_div ? mag2 : mag1;
      end else if (state == CALC) begin
        cnt <= cnt - 1'b1;
        if (op_q[2]) begin
          hi <= diff[XLEN] ? shf[XLEN-1:0] : diff[XLEN-1:0];
          lo <= {lo[XLEN-2:0], ~diff[XLEN]};
        end else begin
          {hi, lo} <= {sum, lo[XLEN-1:1]};
        end
      end
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.result   = res_q;
  assign bus.ex_stall = busy_q | accept;
endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl: directed RV64M corner cases plus random ops.
module tb_muldiv_ctrl;
  localparam int XLEN = 64;
  localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;

  typedef struct {
    logic [63:0] res;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  int          cyc = 0;
  int          errs = 0;
  int          checks = 0;
  exp_t        sb[$];
  logic [63:0] last_res;

  muldiv_ctrl_if #(.XLEN(XLEN)) bus();
  muldiv_ctrl #(.XLEN(XLEN)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] sx32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  // Reference: RISC-V M-extension semantics in plain arithmetic
  function automatic logic [63:0] model(input logic [2:0] op, input logic w,
                                        input logic [63:0] a, input logic [63:0] b);
    logic [127:0]       p;
    logic signed [63:0] sa, sbv;
    logic signed [31:0] wa, wb;
    logic [31:0]        ua, ub, t;
    logic [63:0]        r;
    sa = a; sbv = b; wa = a[31:0]; wb = b[31:0]; ua = a[31:0]; ub = b[31:0];
    t = '0; r = '0;
    case (op)
      3'd0: begin t = ua * ub; r = a * b; if (w) r = sx32(t); end
      3'd1: begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; r = p[127:64]; end
      3'd2: begin p = {{64{a[63]}}, a} * {64'h0, b}; r = p[127:64]; end
      3'd3: begin p = {64'h0, a} * {64'h0, b}; r = p[127:64]; end
      3'd4: begin
        if (w) begin
          if (ub == 0) t = 32'hFFFF_FFFF;
          else if (ua == 32'h8000_0000 && ub == 32'hFFFF_FFFF) t = ua;
          else t = wa / wb;
          r = sx32(t);
        end else begin
          if (b == 0) r = '1;
          else if (a == MIN64 && b == '1) r = a;
          else r = sa / sbv;
        end
      end
      3'd5: begin
        if (w) begin
          if (ub == 0) t = 32'hFFFF_FFFF; else t = ua / ub;
          r = sx32(t);
        end else begin
          if (b == 0) r = '1; else r = a / b;
        end
      end
      3'd6: begin
        if (w) begin
          if (ub == 0) t = ua;
          else if (ua == 32'h8000_0000 && ub == 32'hFFFF_FFFF) t = 0;
          else t = wa % wb;
          r = sx32(t);
        end else begin
          if (b == 0) r = a;
          else if (a == MIN64 && b == '1) r = 0;
          else r = sa % sbv;
        end
      end
      default: begin
        if (w) begin
          if (ub == 0) t = ua; else t = ua % ub;
          r = sx32(t);
        end else begin
          if (b == 0) r = a; else r = a % b;
        end
      end
    endcase
    return r;
  endfunction

  function automatic int latency(input logic [2:0] op, input logic w,
                                 input logic [63:0] a, input logic [63:0] b);
    bit ww, special;
    ww = w && (op == 0 || op[2]);
    special = 0;
    if (op[2]) begin
      if (ww) special = (b[31:0] == 0) ||
                        (!op[0] && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF);
      else    special = (b == 0) || (!op[0] && a == MIN64 && b == '1);
    end
    if (special) return 1;
    return ww ? 34 : 66;
  endfunction

  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL unexpected_done: done=1 result=%h at cycle %0d, expected no done", bus.result, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", bus.result, e.res);
        chk("done_cycle", 64'(cyc), 64'(e.due));
      end
    end
  end

  task automatic run_op(input logic [2:0] op, input logic w, input logic [63:0] a,
                        input logic [63:0] b, input bit hold = 0, input bit use_exp = 0,
                        input logic [63:0] exp_v = '0);
    int   lat, stall_n;
    exp_t e;
    lat   = latency(op, w, a, b);
    e.res = use_exp ? exp_v : model(op, w, a, b);
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.word = w; bus.op1 = a; bus.op2 = b;
    e.due = cyc + lat;
    sb.push_back(e);
    last_res = e.res;
    #1 stall_n = int'(bus.ex_stall);
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      bus.start = hold;
      bus.op  = 3'($urandom);
      bus.op1 = {$urandom, $urandom};
      bus.op2 = {$urandom, $urandom};
      #1;
      if (k < lat) stall_n += int'(bus.ex_stall);
      else chk("stall_in_done", 64'(bus.ex_stall), 64'(0));
    end
    chk("stall_cycles", 64'(stall_n), 64'(lat));
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  function automatic logic [63:0] rnd_val();
    case ($urandom_range(0, 3))
      0:       return {$urandom, $urandom};
      1:       return 64'($urandom_range(1, 300));
      2:       return -64'($urandom_range(1, 300));
      default: return {32'h0, $urandom};
    endcase
  endfunction

  initial begin
    rst = 1'b1;
    bus.start = 1'b0; bus.op = '0; bus.word = 1'b0; bus.op1 = '0; bus.op2 = '0; bus.flush = 1'b0;
    last_res = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", 64'(bus.busy), 64'(0));
    chk("rst_done", 64'(bus.done), 64'(0));
    chk("rst_result", bus.result, 64'(0));
    chk("rst_stall", 64'(bus.ex_stall), 64'(0));
    rst = 1'b0;

    run_op(3'd0, 0, 64'd7, -64'd3, 0, 1, 64'hFFFF_FFFF_FFFF_FFEB);
    run_op(3'd1, 0, MIN64, MIN64, 0, 1, 64'h4000_0000_0000_0000);
    run_op(3'd3, 0, MIN64, MIN64, 0, 1, 64'h4000_0000_0000_0000);
    run_op(3'd2, 0, '1, 64'd2, 0, 1, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op(3'd4, 1, -64'd7, 64'd2, 0, 1, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(3'd6, 1, -64'd7, 64'd2, 0, 1, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op(3'd5, 1, 64'h8000_0000, 64'd1, 0, 1, 64'hFFFF_FFFF_8000_0000);
    run_op(3'd5, 0, 64'd5, 64'd0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op(3'd7, 0, 64'd5, 64'd0, 0, 1, 64'd5);
    run_op(3'd4, 0, MIN64, '1, 0, 1, MIN64);
    run_op(3'd6, 0, MIN64, '1, 0, 1, 64'd0);

    // flush mid-divide: no done, result untouched, restart two cycles later
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'd4; bus.word = 1'b0; bus.op1 = 64'd100; bus.op2 = 64'd7;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    #1;
    chk("flush_busy", 64'(bus.busy), 64'(0));
    chk("flush_result", bus.result, last_res);
    run_op(3'd6, 0, 64'd100, 64'd7, 0, 1, 64'd2);

    // flush coincident with start wins
    @(negedge clk);
    bus.start = 1'b1; bus.flush = 1'b1; bus.op = 3'd5; bus.word = 1'b0; bus.op1 = 64'd9; bus.op2 = 64'd0;
    #1 chk("flush_start_stall", 64'(bus.ex_stall), 64'(0));
    @(negedge clk);
    bus.start = 1'b0; bus.flush = 1'b0;
    #1 chk("flush_start_busy", 64'(bus.busy), 64'(0));

    // start held through DONE with changing operands
    run_op(3'd0, 0, 64'd123, 64'd456, 1);
    run_op(3'd4, 1, 64'hFFFF_FFFF_FFFF_FF00, 64'd3, 1);

    for (int i = 0; i < 24; i++) begin
      logic [2:0]  op;
      logic        w;
      logic [63:0] a, b;
      op = 3'($urandom); w = 1'($urandom); a = rnd_val(); b = rnd_val();
      case ($urandom_range(0, 7))
        0:       b = w ? {$urandom, 32'h0} : 64'h0;
        1:       begin a = w ? 64'h1234_5678_8000_0000 : MIN64; b = w ? 64'h0000_0000_FFFF_FFFF : '1; end
        default: ;
      endcase
      run_op(op, w, a, b, bit'($urandom_range(0, 4) == 0));
    end

    // reset mid-operation
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'd4; bus.word = 1'b0; bus.op1 = 64'd1000; bus.op2 = 64'd3;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("midrst_busy", 64'(bus.busy), 64'(0));
    chk("midrst_result", bus.result, 64'(0));
    chk("midrst_done", 64'(bus.done), 64'(0));
    rst = 1'b0;
    last_res = '0;

    repeat (80) @(negedge clk);
    chk("sb_drained", 64'(sb.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
